// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one column driven low at a time, press and release debounced, 1-cycle key_valid strobe.
// Rows-to-decision latency 2 cycles; no backpressure. Optional auto-repeat when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CYC = 64,
  parameter int REPEAT_CYC   = 1024
) (
  input  logic       ph1,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV) + 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state, state_n;
  logic [3:0]       rows_m, rows_s;
  logic [1:0]       col_idx, col_idx_n;
  logic [1:0]       row_idx, row_idx_n;
  logic [DIV_W-1:0] div_cnt, div_cnt_n;
  logic [DEB_W-1:0] deb_cnt, deb_cnt_n;
  logic [3:0]       key_n;
  logic             key_valid_n, key_held_n;
  logic             row_up, any_low;
  logic [1:0]       row_pri;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYC) + 1;
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYC - 1);
  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT_CYC;
`endif

  assign columns = ~(4'b0001 << col_idx);
  assign row_up  = rows_s[row_idx];
  assign any_low = ~&rows_s;

  // Lowest low row index wins when several rows are pressed.
  always_comb begin
    row_pri = 2'd3;
    for (int i = 3; i >= 0; i--)
      if (!rows_s[i]) row_pri = 2'(i);
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      rows_m    <= 4'hF;
      rows_s    <= 4'hF;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      key       <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_n;
      rows_m    <= rows;
      rows_s    <= rows_m;
      col_idx   <= col_idx_n;
      row_idx   <= row_idx_n;
      div_cnt   <= div_cnt_n;
      deb_cnt   <= deb_cnt_n;
      key       <= key_n;
      key_valid <= key_valid_n;
      key_held  <= key_held_n;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= rep_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    col_idx_n   = col_idx;
    row_idx_n   = row_idx;
    div_cnt_n   = div_cnt;
    deb_cnt_n   = deb_cnt;
    key_n       = key;
    key_valid_n = 1'b0;
    key_held_n  = key_held;
`ifdef KEYPAD_AUTOREPEAT_EN
    // Zero outside HELD, so every entry into HELD restarts the interval.
    rep_cnt_n   = '0;
`endif
    case (state)
      SCAN: begin
        if (div_cnt == DIV_MAX) begin
          div_cnt_n = '0;
          if (any_low) begin
            row_idx_n = row_pri;
            deb_cnt_n = '0;
            state_n   = DEBOUNCE;
          end else begin
            col_idx_n = col_idx + 2'd1;
          end
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_up) begin
          state_n   = SCAN;
          div_cnt_n = '0;
          col_idx_n = col_idx + 2'd1;
        end else if (deb_cnt == DEB_MAX) begin
          key_n       = {col_idx, row_idx};
          key_valid_n = 1'b1;
          key_held_n  = 1'b1;
          state_n     = HELD;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (row_up) begin
          deb_cnt_n = '0;
          state_n   = RELEASE;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rep_cnt == REP_MAX) begin
          key_valid_n = 1'b1;
          rep_cnt_n   = '0;
        end else begin
          rep_cnt_n = rep_cnt + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (!row_up) begin
          state_n = HELD;
        end else if (deb_cnt == DEB_MAX) begin
          key_held_n = 1'b0;
          state_n    = SCAN;
          div_cnt_n  = '0;
          col_idx_n  = col_idx + 2'd1;
        end else begin
          deb_cnt_n = deb_cnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model drives rows from columns; key strobes checked via a scoreboard queue.
module tb_keypad_scan_ctrl;
  logic       ph1 = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] columns, key;
  logic       key_valid, key_held;

  logic [3:0] pressed [4];
  logic [3:0] exp_q [$];
  logic [3:0] exp_key;
  logic [3:0] prev_key = 4'd0;
  logic       prev_vld = 1'b0;
  logic [3:0] expc;
  int         checks = 0;
  int         failures = 0;
  int         n;

  always #5 ph1 = ~ph1;

  // A pressed switch pulls its row low only while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!columns[c]) rows = rows & ~pressed[c];
  end

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYC(8), .REPEAT_CYC(32)) dut (
    .ph1(ph1), .reset(reset), .rows(rows), .columns(columns),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic tick(input int cyc);
    repeat (cyc) @(negedge ph1);
  endtask

  task automatic wait_col(input logic [3:0] target);
    int k;
    k = 0;
    while (columns !== target && k < 40) begin
      @(negedge ph1);
      k++;
    end
    check("wait_col", columns, target);
  endtask

  // Monitor: every strobe must match the next queued key; key may only move with a strobe.
  always @(negedge ph1) begin
    if (!reset) begin
      prev_key = key;
      prev_vld = 1'b0;
    end else begin
      if (key_valid) begin
        check("strobe_gap", {3'b000, prev_vld}, 4'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got key %b required no strobe", key);
        end else begin
          exp_key = exp_q.pop_front();
          check("strobe_key", key, exp_key);
        end
      end else if (key !== prev_key) begin
        check("key_stable", key, prev_key);
      end
      prev_key = key;
      prev_vld = key_valid;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) pressed[i] = 4'd0;
    #2 reset = 1'b0;
    tick(3);
    check("rst_columns", columns, 4'b1110);
    check("rst_key", key, 4'd0);
    check("rst_valid", {3'b000, key_valid}, 4'd0);
    check("rst_held", {3'b000, key_held}, 4'd0);
    reset = 1'b1;

    // Idle scan: column advances every 4 cycles.
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      expc = ~(4'b0001 << ((k / 4) % 4));
      check("idle_columns", columns, expc);
    end
    check("idle_key", key, 4'd0);

    // Column 2 / row 2 press and debounced release.
    pressed[2] = 4'b0100;
    exp_q.push_back(4'b1010);
    tick(30);
    check("c2r2_columns", columns, 4'b1011);
    check("c2r2_held", {3'b000, key_held}, 4'd1);
    check("c2r2_key", key, 4'b1010);
    pressed[2] = 4'b0000;
    tick(8);
    check("c2r2_rel_held", {3'b000, key_held}, 4'd1);
    tick(4);
    check("c2r2_rel_done", {3'b000, key_held}, 4'd0);
    check("c2r2_next_col", columns, 4'b0111);

    // Short bounce on column 0 / row 1 is rejected.
    wait_col(4'b1110);
    pressed[0] = 4'b0010;
    tick(7);
    check("bounce_frozen", columns, 4'b1110);
    pressed[0] = 4'b0000;
    tick(4);
    check("bounce_columns", columns, 4'b1101);
    check("bounce_key", key, 4'b1010);
    check("bounce_held", {3'b000, key_held}, 4'd0);

    // Release glitch while held: no second strobe, held stays high.
    pressed[1] = 4'b1000;
    exp_q.push_back(4'b0111);
    tick(30);
    check("c1r3_key", key, 4'b0111);
    check("c1r3_held", {3'b000, key_held}, 4'd1);
    pressed[1] = 4'b0000;
    tick(4);
    check("glitch_held", {3'b000, key_held}, 4'd1);
    pressed[1] = 4'b1000;
    tick(6);
    check("repress_held", {3'b000, key_held}, 4'd1);
    check("repress_columns", columns, 4'b1101);
    pressed[1] = 4'b0000;
    tick(12);
    check("c1r3_rel_done", {3'b000, key_held}, 4'd0);
    check("c1r3_next_col", columns, 4'b1011);

    // Two rows on column 3: row 0 wins.
    pressed[3] = 4'b0101;
    exp_q.push_back(4'b1100);
    tick(30);
    check("prio_columns", columns, 4'b0111);
    check("prio_key", key, 4'b1100);
    pressed[3] = 4'b0000;
    tick(12);
    check("prio_rel_held", {3'b000, key_held}, 4'd0);
    check("prio_next_col", columns, 4'b1110);

    // Reset in the middle of debounce.
    wait_col(4'b1101);
    pressed[1] = 4'b0010;
    tick(6);
    #1 reset = 1'b0;
    #1;
    check("midrst_columns", columns, 4'b1110);
    check("midrst_key", key, 4'd0);
    check("midrst_valid", {3'b000, key_valid}, 4'd0);
    check("midrst_held", {3'b000, key_held}, 4'd0);
    pressed[1] = 4'b0000;
    tick(2);
    reset = 1'b1;
    tick(5);
    check("postrst_columns", columns, 4'b1101);

`ifdef KEYPAD_AUTOREPEAT_EN
    // Long hold: acceptance strobe plus repeats 32 and 64 cycles later.
    pressed[2] = 4'b0001;
    repeat (3) exp_q.push_back(4'b1000);
    n = 0;
    while (!key_held && n < 40) begin
      tick(1);
      n++;
    end
    check("rep_accept", {3'b000, key_held}, 4'd1);
    tick(70);
    pressed[2] = 4'b0000;
    tick(12);
    check("rep_rel_held", {3'b000, key_held}, 4'd0);
`endif

    tick(10);
    check("queue_empty", 4'(exp_q.size()), 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequences the 4x4 matrix keypad datapath.
- Drives one column low at a time and samples the four row inputs.
- Debounces both press and release.
- Emits a 4-bit key code with a one-cycle valid strobe.
- Sits between the keypad pins and the e155ASIC mode/display logic, replacing ad-hoc scanning in the top level.

Parameters:
- SCAN_DIV, 16, clock cycles each column is driven before advancing (>=2).
- DEBOUNCE_CYC, 64, consecutive stable cycles required to accept a press or a release (>=2).
- REPEAT_CYC, 1024, auto-repeat interval in cycles; used only when KEYPAD_AUTOREPEAT_EN is defined.

Ports:
- ph1  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- rows  input  4  keypad rows, active-low with external pull-ups, asynchronous to ph1.
- columns  output  4  keypad column drive, active-low one-hot (exactly one bit 0).
- key  output  4  last accepted key code {col_idx[1:0], row_idx[1:0]}.
- key_valid  output  1  one-cycle strobe when key is updated.
- key_held  output  1  high while the accepted key remains pressed.

Behaviour:
- Reset (reset=0, async): columns=4'b1110 (col 0), key=0, key_valid=0, key_held=0, state=SCAN, all counters 0, synchronizer flops=4'b1111.
- rows passes through a 2-flop synchronizer (rows_s); all decisions use rows_s only. Input-to-decision latency is 2 cycles.
- Counters: div_cnt counts 0..SCAN_DIV-1. deb_cnt counts 0..DEBOUNCE_CYC-1. rep_cnt (optional feature only) counts 0..REPEAT_CYC-1. Each counter is $clog2(max)+1 bits wide. No counter ever wraps outside its range.
- Row priority: if several rows_s bits are low, the lowest row index wins. Across columns, the first column reached in scan order 0,1,2,3,0,... wins.
- SCAN state:
  - div_cnt increments every cycle.
  - At div_cnt==SCAN_DIV-1, sample rows_s.
  - If any bit is 0: latch col_idx and row_idx, clear deb_cnt, go to DEBOUNCE. The column does not advance.
  - Otherwise: clear div_cnt and rotate to the next column (3 wraps to 0).
- DEBOUNCE state:
  - columns held on the latched column.
  - Latched row high on any cycle: return to SCAN, div_cnt=0, advance to the next column. key is unchanged and no strobe is issued.
  - Latched row low with deb_cnt==DEBOUNCE_CYC-1: on the next edge key<={col_idx,row_idx}, key_valid=1 for exactly that cycle, key_held=1, go to HELD.
  - Otherwise deb_cnt increments.
- HELD state:
  - columns held, key_held=1.
  - Latched row high: clear deb_cnt, go to RELEASE.
  - Other rows changing are ignored.
- RELEASE state:
  - Latched row low on any cycle: return to HELD. No strobe, key_held stays 1.
  - Latched row high with deb_cnt==DEBOUNCE_CYC-1: key_held<=0, go to SCAN at the next column with div_cnt=0.
  - key retains its value.
- key_valid is never high for two consecutive cycles. key changes only in the same cycle key_valid is asserted.
- Reset asserted mid-operation in any state aborts immediately to reset values; no strobe is issued.

Optional Feature:
- KEYPAD_AUTOREPEAT_EN defined:
  - In HELD, rep_cnt increments every cycle from 0 (cleared on entry to HELD).
  - At rep_cnt==REPEAT_CYC-1, key_valid pulses 1 cycle with key unchanged, and rep_cnt clears.
  - rep_cnt also clears on entering RELEASE. A bounce back into HELD restarts it from 0.
- Not defined: no rep_cnt logic, REPEAT_CYC is ignored, and exactly one key_valid is issued per debounced press.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=32):
- Reset, rows=1111 for 40 cycles -> columns steps 1110,1101,1011,0111,1110 every 4 cycles; key_valid never 1; key=0.
- rows[2] low only while columns=1011, held for 30 cycles -> columns freezes at 1011; exactly one key_valid with key=4'b1010; key_held=1 until release debounce completes.
- Press row1/col0 for 3 cycles, then release (bounce) -> no key_valid; key stays at its prior value; scan resumes at column 1 (1101).
- In HELD, release for 4 cycles then press again -> key_held stays 1, no second strobe; a subsequent 10-cycle release -> key_held=0 and scanning resumes at the next column.
- rows=1010 (rows 0 and 2) on column 3 -> key=4'b1100 (row 0 wins); single strobe.
- Assert reset low mid-DEBOUNCE -> outputs immediately columns=1110, key=0, key_valid=0, key_held=0. With KEYPAD_AUTOREPEAT_EN and a 100-cycle hold -> key_valid pulses at acceptance and every 32 cycles after, all with the same key.
